// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch feeding ins_decoder through a 2-entry prefetch queue; IRQ vectoring under `IRQ_VECTOR_EN.
// Latency: a read issued in cycle N is on IR in N+2; a redirect target reaches IR 4 cycles after LPCS.
// Backpressure: issue stalls once queued words plus the in-flight read fill both slots; HOLD stops issue, queue kept.
module ifetch_unit #(
    parameter logic [17:0] RESET_VECTOR = 18'h00000,
    parameter logic [17:0] VEC0         = 18'h00004,
    parameter logic [17:0] VEC1         = 18'h00008
) (
    input  logic        clk,
    input  logic        RESET,
    output logic [17:0] IM_ADDRBUS,
    output logic        RDIM,
    input  logic [15:0] IM_DATABUS,
    output logic [15:0] IR,
    output logic [17:0] IR_PC,
    output logic        IR_VALID,
    input  logic        LIR,
    input  logic        LPCS,
    input  logic [17:0] PCS_DATABUS,
    input  logic        HOLD,
    input  logic        I0,
    input  logic        I1,
    input  logic        IE,
    output logic        IRQ_ACK,
    output logic [17:0] EPC
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HOLDING} state_t;

    typedef struct packed {
        logic [17:0] pc;
        logic [15:0] dat;
    } qent_t;

    state_t      state_q, state_d;
    logic [17:0] pc_q;
    logic        rd_vld_q;
    logic [17:0] rd_pc_q;
    logic [1:0]  count_q;
    qent_t       q_ent [2];

    logic        accept;
    logic        issue;
    logic        redirect;
    logic        irq_take;
    logic [17:0] irq_vec;
    logic [17:0] redirect_pc;
    logic [1:0]  occupancy;
    qent_t       fill_ent;

    assign IR_VALID    = (count_q != 2'd0);
    assign IR          = q_ent[0].dat;
    assign IR_PC       = q_ent[0].pc;
    assign accept      = IR_VALID & LIR;
    assign redirect    = LPCS | irq_take;
    assign redirect_pc = LPCS ? PCS_DATABUS : irq_vec;
    assign fill_ent    = '{pc: rd_pc_q, dat: IM_DATABUS};

    // Counting the word leaving this cycle lets issue run every cycle while LIR stays high.
    assign occupancy = count_q + {1'b0, rd_vld_q} - {1'b0, accept};
    assign issue     = (state_q == RUN) && !HOLD && !redirect && (occupancy < 2'd2);

    assign RDIM       = issue;
    assign IM_ADDRBUS = pc_q;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = HOLD ? HOLDING : RUN;
                FLUSH:   state_d = HOLD ? HOLDING : RUN;
                HOLDING: state_d = HOLD ? HOLDING : RUN;
                default: state_d = BOOT;
            endcase
        end
    end

    // A redirect drops the queue and the read in flight: its data arrives while the flush
    // is being applied, and no read issues in the redirect cycle itself.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            pc_q     <= RESET_VECTOR;
            rd_vld_q <= 1'b0;
            rd_pc_q  <= '0;
            count_q  <= 2'd0;
            q_ent[0] <= '0;
            q_ent[1] <= '0;
        end else if (redirect) begin
            pc_q     <= redirect_pc;
            rd_vld_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_vld_q <= issue;
            if (issue) begin
                pc_q    <= pc_q + 18'd1;
                rd_pc_q <= pc_q;
            end
            case ({rd_vld_q, accept})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        q_ent[0] <= fill_ent;
                    end else begin
                        q_ent[1] <= fill_ent;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    q_ent[0] <= q_ent[1];
                    count_q  <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        q_ent[0] <= fill_ent;
                    end else begin
                        q_ent[0] <= q_ent[1];
                        q_ent[1] <= fill_ent;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IRQ_VECTOR_EN
    logic        irq_armed_q;
    logic        irq_ack_q;
    logic [17:0] epc_q;
    logic [17:0] epc_src;

    assign irq_take = (state_q == RUN) && !LPCS && IE && (I0 || I1) && irq_armed_q;
    assign irq_vec  = I0 ? VEC0 : VEC1;
    // Oldest instruction not yet handed to the decoder.
    assign epc_src  = IR_VALID ? q_ent[0].pc : (rd_vld_q ? rd_pc_q : pc_q);

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            irq_armed_q <= 1'b1;
            irq_ack_q   <= 1'b0;
            epc_q       <= '0;
        end else begin
            irq_ack_q <= irq_take;
            if (irq_take) begin
                epc_q       <= epc_src;
                irq_armed_q <= 1'b0;
            end else if (!IE) begin
                irq_armed_q <= 1'b1;
            end
        end
    end

    assign IRQ_ACK = irq_ack_q;
    assign EPC     = epc_q;
`else
    logic unused_irq;
    assign unused_irq = ^{I0, I1, IE, VEC0, VEC1};
    assign irq_take   = 1'b0;
    assign irq_vec    = RESET_VECTOR;
    assign IRQ_ACK    = 1'b0;
    assign EPC        = '0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed phases, decoder transfers checked against a queue of expected words.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] im_addr;
    logic        rdim;
    logic [15:0] im_data;
    logic [15:0] ir;
    logic [17:0] ir_pc;
    logic        ir_valid;
    logic        lir;
    logic        lpcs;
    logic [17:0] pcs;
    logic        hold;
    logic        i0;
    logic        i1;
    logic        ie;
    logic        irq_ack;
    logic [17:0] epc;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [17:0] pc;
        logic [15:0] dat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk         (clk),
        .RESET       (rst),
        .IM_ADDRBUS  (im_addr),
        .RDIM        (rdim),
        .IM_DATABUS  (im_data),
        .IR          (ir),
        .IR_PC       (ir_pc),
        .IR_VALID    (ir_valid),
        .LIR         (lir),
        .LPCS        (lpcs),
        .PCS_DATABUS (pcs),
        .HOLD        (hold),
        .I0          (i0),
        .I1          (i1),
        .IE          (ie),
        .IRQ_ACK     (irq_ack),
        .EPC         (epc)
    );

    // Instruction memory: word = address[15:0], returned the cycle after the strobe.
    always @(posedge clk) im_data <= rdim ? im_addr[15:0] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [17:0] pc);
        exp_t e;
        e.pc  = pc;
        e.dat = pc[15:0];
        sb.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdim"},    32'(rdim),     32'd0);
        chk({tag, "_addr"},    32'(im_addr),  32'd0);
        chk({tag, "_valid"},   32'(ir_valid), 32'd0);
        chk({tag, "_ir"},      32'(ir),       32'd0);
        chk({tag, "_ir_pc"},   32'(ir_pc),    32'd0);
        chk({tag, "_irq_ack"}, 32'(irq_ack),  32'd0);
        chk({tag, "_epc"},     32'(epc),      32'd0);
    endtask

    // Monitor: every decoder transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && ir_valid && lir) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got IR_PC=%05h IR=%04h, expected no transfer", ir_pc, ir);
            end else begin
                mon_e = sb.pop_front();
                chk("word_pc",  32'(ir_pc), 32'(mon_e.pc));
                chk("word_dat", 32'(ir),    32'(mon_e.dat));
            end
        end
    end

    int          npulse;
    int          unstable;
    int          nack;
    logic [17:0] paddr [4];

    initial begin
        rst = 1'b1; lir = 1'b0; lpcs = 1'b0; pcs = '0;
        hold = 1'b0; i0 = 1'b0; i1 = 1'b0; ie = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk_reset("por");

        // Streaming from reset with LIR held high.
        for (int a = 0; a < 8; a++) expect_word(18'(a));
        tick(); rst = 1'b0; lir = 1'b1;              // BOOT cycle
        @(negedge clk);
        chk("boot_rdim",  32'(rdim),     32'd0);
        chk("boot_valid", 32'(ir_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("fetch0_rdim", 32'(rdim),    32'd1);
        chk("fetch0_addr", 32'(im_addr), 32'd0);
        tick();
        @(negedge clk);
        chk("fetch1_addr",  32'(im_addr),  32'd1);
        chk("fetch1_valid", 32'(ir_valid), 32'd0);
        for (int k = 4; k <= 11; k++) begin
            tick();
            @(negedge clk);
            if (k == 4) chk("first_valid", 32'(ir_valid), 32'd1);
        end
        chk("stream_rdim", 32'(rdim),    32'd1);
        chk("stream_addr", 32'(im_addr), 32'd9);

        // Reset while a read is being issued.
        tick(); rst = 1'b1;
        @(negedge clk);
        chk_reset("mid_reset");
        chk("sb_drain_stream", 32'(sb.size()), 32'd0);

        // LIR low from reset: two reads fill the queue, then nothing.
        tick(); lir = 1'b0;
        tick(); rst = 1'b0;
        npulse = 0; unstable = 0;
        for (int i = 0; i < 4; i++) paddr[i] = '1;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            @(negedge clk);
            if (rdim) begin
                if (npulse < 4) paddr[npulse] = im_addr;
                npulse++;
            end
            if (k >= 4 && (!ir_valid || ir != 16'h0000)) unstable++;
        end
        chk("fill_pulses",   32'(npulse),   32'd2);
        chk("fill_addr0",    32'(paddr[0]), 32'd0);
        chk("fill_addr1",    32'(paddr[1]), 32'd1);
        chk("fill_unstable", 32'(unstable), 32'd0);
        for (int a = 0; a < 6; a++) expect_word(18'(a));
        tick(); lir = 1'b1;
        repeat (5) tick();

        // Redirect with a read in flight; the stale word must never reach IR.
        tick(); lir = 1'b0; lpcs = 1'b1; pcs = 18'h00100;
        @(negedge clk);
        chk("sb_drain_fill", 32'(sb.size()), 32'd0);
        chk("redir_rdim",    32'(rdim),      32'd0);
        for (int a = 0; a < 4; a++) expect_word(18'h00100 + 18'(a));
        tick(); lpcs = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(ir_valid), 32'd0);
        chk("flush_rdim",  32'(rdim),     32'd0);
        tick();
        @(negedge clk);
        chk("tgt_valid2", 32'(ir_valid), 32'd0);
        chk("tgt_rdim",   32'(rdim),     32'd1);
        chk("tgt_addr",   32'(im_addr),  32'h00100);
        tick();
        @(negedge clk);
        chk("tgt_valid3", 32'(ir_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("tgt_valid4", 32'(ir_valid), 32'd1);
        chk("tgt_ir_pc",  32'(ir_pc),    32'h00100);
        tick(); lir = 1'b1;
        repeat (3) tick();

        // PC wrap from the top of the address space.
        tick(); lir = 1'b0; lpcs = 1'b1; pcs = 18'h3FFFF;
        @(negedge clk);
        chk("sb_drain_redir", 32'(sb.size()), 32'd0);
        expect_word(18'h3FFFF);
        expect_word(18'h00000);
        expect_word(18'h00001);
        tick(); lpcs = 1'b0; lir = 1'b1;
        @(negedge clk);
        chk("wrap_flush_rdim", 32'(rdim), 32'd0);
        tick();
        @(negedge clk);
        chk("wrap_addr0", 32'(im_addr), 32'h3FFFF);
        tick();
        @(negedge clk);
        chk("wrap_addr1", 32'(im_addr), 32'h00000);
        tick();
        @(negedge clk);
        chk("wrap_rdim2", 32'(rdim),    32'd1);
        chk("wrap_addr2", 32'(im_addr), 32'h00001);
        tick();
        tick();

        // HOLD: queue drains to the decoder, no new reads until release.
        expect_word(18'd2);
        expect_word(18'd3);
        expect_word(18'd4);
        expect_word(18'd5);
        tick(); hold = 1'b1;
        @(negedge clk);
        chk("hold_rdim0", 32'(rdim), 32'd0);
        tick();
        @(negedge clk);
        chk("hold_rdim1", 32'(rdim), 32'd0);
        tick();
        @(negedge clk);
        chk("hold_rdim2",  32'(rdim),     32'd0);
        chk("hold_empty",  32'(ir_valid), 32'd0);
        tick(); hold = 1'b0;
        @(negedge clk);
        chk("unhold_rdim", 32'(rdim), 32'd0);
        tick();
        @(negedge clk);
        chk("resume_rdim", 32'(rdim),    32'd1);
        chk("resume_addr", 32'(im_addr), 32'd4);
        tick();
        tick();
        @(negedge clk);
        chk("resume_valid", 32'(ir_valid), 32'd1);
        tick();

`ifdef IRQ_VECTOR_EN
        tick(); lir = 1'b0; lpcs = 1'b1; pcs = 18'h00020;
        tick(); lpcs = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("irq_head_pc", 32'(ir_pc), 32'h00020);
        tick(); i0 = 1'b1; i1 = 1'b1; ie = 1'b1;
        tick();
        @(negedge clk);
        chk("irq_ack",     32'(irq_ack), 32'd1);
        chk("irq_epc",     32'(epc),     32'h00020);
        nack = 0;
        for (int k = 2; k <= 6; k++) begin
            tick();
            @(negedge clk);
            if (irq_ack) nack++;
            if (k == 4) begin
                chk("irq_vec_valid", 32'(ir_valid), 32'd1);
                chk("irq_vec_pc",    32'(ir_pc),    32'h00004);
            end
        end
        chk("irq_no_retake", 32'(nack), 32'd0);
        tick(); ie = 1'b0;
        tick(); ie = 1'b1;
        tick();
        @(negedge clk);
        chk("irq_rearm_ack", 32'(irq_ack), 32'd1);
        chk("irq_rearm_epc", 32'(epc),     32'h00004);
`else
        tick(); lir = 1'b0; i0 = 1'b1; i1 = 1'b1; ie = 1'b1;
        tick();
        @(negedge clk);
        chk("noirq_ack0", 32'(irq_ack), 32'd0);
        chk("noirq_epc0", 32'(epc),     32'd0);
        tick();
        @(negedge clk);
        chk("noirq_ack1",  32'(irq_ack),  32'd0);
        chk("noirq_epc1",  32'(epc),      32'd0);
        chk("noirq_valid", 32'(ir_valid), 32'd1);
        chk("noirq_ir_pc", 32'(ir_pc),    32'd6);
`endif

        chk("sb_final", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
